uart_boot_loader: RTL and testbench
===================================

Name: uart_boot_loader

Overview:
Consumes the serial program image that the SoC testbench drives on uart_rx_i: 8N1 bytes, LSB-first, with each 32-bit instruction sent as four bytes, least-significant byte first. The block deserialises the bytes and assembles them into little-endian 32-bit words. It writes each word to instruction memory through a req/gnt port at consecutive word addresses. It holds the core in reset until loading completes, then releases it.

Parameters:
CLK_FREQ, 10000000, system clock frequency in Hz.
BAUD, 115200, UART bit rate.
CLKS_PER_BIT, CLK_FREQ/BAUD+1 (87), clock cycles per UART bit.
ADDR_W, 12, word-address width.
MEM_WORDS, 4096, capacity in words; loading stops when this is reached.
END_WORD, 32'h0000_0FFF, terminator word; it is not written to memory.

Ports:
clk_i  in  1  system clock.
rst_ni  in  1  reset; asynchronous, active-low.
uart_rx_i  in  1  serial input; idles high; asynchronous to clk_i.
mem_req_o  out  1  write request.
mem_we_o  out  1  write enable; equals mem_req_o.
mem_addr_o  out  ADDR_W  word address.
mem_wdata_o  out  32  write data.
mem_be_o  out  4  byte enables; constant 4'hF.
mem_gnt_i  in  1  grant; the write completes in a cycle where req and gnt are both high.
boot_done_o  out  1  loading finished.
core_rst_no  out  1  core reset, active-low; equals boot_done_o.
frame_err_o  out  1  sticky; set when a bad stop bit is seen.
overrun_o  out  1  sticky; set when a word is dropped because a write is still pending.
word_cnt_o  out  ADDR_W+1  number of words written to memory.

Behaviour:
- Reset values: all outputs 0 except mem_be_o=4'hF. Reset asserted mid-byte or mid-write aborts everything: the counters and byte buffer clear, and any pending request drops immediately.
- Input synchroniser: 2-flop synchroniser on uart_rx_i, reset value 1. All edge detection and sampling use the synchronised value.
- RX FSM: RX_IDLE -> RX_START -> RX_DATA -> RX_STOP -> RX_IDLE.
  - RX_IDLE: waits for a falling edge on the synchronised input.
  - RX_START: waits CLKS_PER_BIT/2 (43) cycles. If the line is high at that point, it is a false start: return to RX_IDLE with no byte and no flag. If low, go to RX_DATA.
  - RX_DATA: samples 8 bits, one every CLKS_PER_BIT cycles, at bit centres. Bit 0 is the LSB.
  - RX_STOP: samples one CLKS_PER_BIT later. If high, pulse byte_valid (internal) for 1 cycle. If low, set frame_err_o and discard the byte.
  - The FSM returns to RX_IDLE immediately after the stop sample. This allows back-to-back frames.
- Word assembly:
  - A 2-bit byte index k places each byte into buf[8k+7:8k].
  - On the 4th byte, the full word is taken (the combinational {byte, buf[23:0]}) and k wraps to 0.
  - If the word equals END_WORD, go to DONE and write nothing.
  - Otherwise, if no write is pending, load mem_wdata_o and mem_addr_o=word_cnt_o[ADDR_W-1:0], and set mem_req_o on the next cycle.
  - If a write is still pending, set overrun_o, drop the word, and leave the address unchanged.
- Load FSM states: LOAD, WRITE, DONE.
  - LOAD -> WRITE when a word is issued.
  - WRITE holds mem_req_o, mem_addr_o and mem_wdata_o stable until the grant.
  - On a cycle with req&gnt: deassert req next cycle and increment word_cnt_o.
    - If word_cnt_o then equals MEM_WORDS, go to DONE.
    - Otherwise return to LOAD.
  - Minimum write latency: the 4th stop-bit sample plus 1 cycle to mem_req_o. With gnt tied high, req is high for exactly 1 cycle.
- DONE:
  - boot_done_o=1 and core_rst_no=1 from the cycle after entry. They stay high until reset.
  - Further RX bytes are still framed (frame_err_o is still updated) but are ignored for assembly and never written.
- The byte buffer persists across idle gaps. There is no inter-byte timeout.
- A framing error does not advance k.

Test Plan:
- Basic load: send bytes 13 01 20 00, then B7 00 00 10, then FF 0F 00 00 with gnt tied 1.
  -> Writes (addr 0, 0x00200113) and (addr 1, 0x100000B7).
  -> word_cnt_o=2.
  -> boot_done_o and core_rst_no rise 1 cycle after the last stop sample.
- False start: drive rx low for 20 cycles, then high, then send 4 valid bytes.
  -> No byte is produced from the glitch.
  -> Exactly one write, with the correct data; frame_err_o stays 0.
- Framing error: send byte 0x55 with stop bit 0, then bytes 13 01 20 00.
  -> frame_err_o=1.
  -> The 0x55 byte is discarded; the word written is 0x00200113 at addr 0.
- Grant stall and overrun: hold gnt=0 while sending 8 bytes forming 0x11111111 and 0x22222222.
  -> req and data for 0x11111111 stay stable throughout.
  -> The second word is dropped and overrun_o=1.
  -> After gnt=1: a single write at addr 0; word_cnt_o=1.
- Reset mid-byte: assert rst_ni low during bit 4 of byte 2, release, then send 13 01 20 00.
  -> All outputs are at reset values during reset.
  -> After release, the write is 0x00200113 at addr 0 (no stale bytes).
- Capacity: MEM_WORDS=2, send 3 words with no END_WORD.
  -> Writes at addr 0 and 1 only.
  -> boot_done_o=1 after the second grant; the third word is ignored.

Source files
------------

// File: rtl/uart_boot_loader.sv
// UART boot loader: 8N1 receiver, little-endian word assembly,
// instruction-memory writer and core reset release.
module uart_boot_loader #(
  parameter int unsigned CLK_FREQ     = 10_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD + 1,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned MEM_WORDS    = 4096,
  parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              uart_rx_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic              mem_gnt_i,
  output logic              boot_done_o,
  output logic              core_rst_no,
  output logic              frame_err_o,
  output logic              overrun_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0] CAP   = (ADDR_W + 1)'(MEM_WORDS);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_e;

  typedef enum logic [1:0] {
    LOAD, WRITE, DONE
  } ld_e;

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  rx_e           rx_q, rx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          fe_q, fe_d;
  logic          byte_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_q      <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      fe_q      <= 1'b0;
    end else begin
      rx_s1_q   <= uart_rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      fe_q      <= fe_d;
    end
  end

  always_comb begin
    rx_d       = rx_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    fe_d       = fe_q;
    byte_valid = 1'b0;
    unique case (rx_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_d  = RX_START;
          cnt_d = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          rx_d  = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          sh_d  = {rx_s2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          rx_d  = RX_IDLE;
          if (rx_s2_q) byte_valid = 1'b1;
          else         fe_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  ld_e               ld_q, ld_d;
  logic [1:0]        k_q, k_d;
  logic [23:0]       buf_q, buf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic              ov_q, ov_d;
  logic [31:0]       word;
  logic [ADDR_W:0]   wcnt_inc;

  assign word     = {sh_q, buf_q};
  assign wcnt_inc = wcnt_q + (ADDR_W + 1)'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ld_q    <= LOAD;
      k_q     <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wcnt_q  <= '0;
      ov_q    <= 1'b0;
    end else begin
      ld_q    <= ld_d;
      k_q     <= k_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wcnt_q  <= wcnt_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    ld_d    = ld_q;
    k_d     = k_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wcnt_d  = wcnt_q;
    ov_d    = ov_q;
    if (ld_q == WRITE && mem_gnt_i) begin
      wcnt_d = wcnt_inc;
      ld_d   = (wcnt_inc == CAP) ? DONE : LOAD;
    end
    // A word landing while the previous write waits is dropped.
    if (byte_valid && ld_q != DONE) begin
      k_d = k_q + 2'd1;
      unique case (k_q)
        2'd0: buf_d[7:0]   = sh_q;
        2'd1: buf_d[15:8]  = sh_q;
        2'd2: buf_d[23:16] = sh_q;
        default: begin
          if (word == END_WORD) begin
            ld_d = DONE;
          end else if (ld_q == LOAD) begin
            addr_d  = wcnt_q[ADDR_W-1:0];
            wdata_d = word;
            ld_d    = WRITE;
          end else begin
            ov_d = 1'b1;
          end
        end
      endcase
    end
  end

  assign mem_req_o   = (ld_q == WRITE);
  assign mem_we_o    = mem_req_o;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = 4'hF;
  assign boot_done_o = (ld_q == DONE);
  assign core_rst_no = boot_done_o;
  assign frame_err_o = fe_q;
  assign overrun_o   = ov_q;
  assign word_cnt_o  = wcnt_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: directed scenarios plus a random
// image, checked against a byte-stream reference model.
module tb_uart_boot_loader;

  localparam int CPB = 87;
  localparam logic [31:0] ENDW = 32'h0000_0FFF;

  typedef struct packed {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;
  typedef logic [7:0] bq_t[$];
  typedef wr_t wq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic gnt = 1'b1;

  logic        a_req, a_we, a_done, a_crst, a_fe, a_ov;
  logic [11:0] a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_be;
  logic [12:0] a_cnt;
  logic        b_req, b_we, b_done, b_crst, b_fe, b_ov;
  logic [11:0] b_addr;
  logic [31:0] b_wdata;
  logic [3:0]  b_be;
  logic [12:0] b_cnt;

  uart_boot_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i(clk), .rst_ni(rst_n), .uart_rx_i(rx),
    .mem_req_o(a_req), .mem_we_o(a_we),
    .mem_addr_o(a_addr), .mem_wdata_o(a_wdata),
    .mem_be_o(a_be), .mem_gnt_i(gnt),
    .boot_done_o(a_done), .core_rst_no(a_crst),
    .frame_err_o(a_fe), .overrun_o(a_ov),
    .word_cnt_o(a_cnt)
  );

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .MEM_WORDS(2)) dut_cap (
    .clk_i(clk), .rst_ni(rst_n), .uart_rx_i(rx),
    .mem_req_o(b_req), .mem_we_o(b_we),
    .mem_addr_o(b_addr), .mem_wdata_o(b_wdata),
    .mem_be_o(b_be), .mem_gnt_i(gnt),
    .boot_done_o(b_done), .core_rst_no(b_crst),
    .frame_err_o(b_fe), .overrun_o(b_ov),
    .word_cnt_o(b_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  wr_t got_a[$];
  wr_t got_b[$];
  int req_cyc_a = 0;

  always @(negedge clk) begin
    #3;
    if (a_req && gnt) got_a.push_back({a_addr, a_wdata});
    if (b_req && gnt) got_b.push_back({b_addr, b_wdata});
    if (a_req) req_cyc_a++;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_head(input logic [7:0] b);
    rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(CPB);
    end
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic stop = 1'b1);
    send_head(b);
    rx = stop;
    cyc(CPB);
    rx = 1'b1;
    cyc(2);
  endtask

  task automatic send_list(input bq_t bs, input int gap);
    foreach (bs[i]) begin
      send_byte(bs[i]);
      cyc($urandom_range(gap, 0));
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic chk_rst();
    chk("rst_a_mem", {a_req, a_we, a_addr, a_wdata}, 64'd0);
    chk("rst_a_ctl", {a_be, a_done, a_crst, a_fe, a_ov, a_cnt},
        {4'hF, 4'b0, 13'd0});
    chk("rst_b_mem", {b_req, b_we, b_addr, b_wdata}, 64'd0);
    chk("rst_b_ctl", {b_be, b_done, b_crst, b_fe, b_ov, b_cnt},
        {4'hF, 4'b0, 13'd0});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    cyc(3);
    chk_rst();
    got_a.delete();
    got_b.delete();
    req_cyc_a = 0;
    rst_n = 1'b1;
    cyc(5);
  endtask

  function automatic wq_t model(bq_t bs, int cap);
    wq_t q;
    logic [31:0] w;
    int n = 0;
    for (int i = 0; i + 3 < bs.size(); i += 4) begin
      w = {bs[i+3], bs[i+2], bs[i+1], bs[i]};
      if (w == ENDW) break;
      q.push_back({12'(n), w});
      n++;
      if (n == cap) break;
    end
    return q;
  endfunction

  task automatic cmp(input string tag, input wq_t got,
                     input wq_t exp);
    chk({tag, "_n"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(tag, 64'(got[i]), 64'(exp[i]));
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if (w == ENDW) w = w ^ 32'h1;
    return w;
  endfunction

  initial begin
    bq_t bs;
    bq_t all;
    logic [31:0] w;
    int nw;

    cyc(2);
    do_reset();

    // basic load with terminator
    bs = '{8'h13, 8'h01, 8'h20, 8'h00,
           8'hB7, 8'h00, 8'h00, 8'h10};
    send_list(bs, 0);
    send_byte(8'hFF);
    send_byte(8'h0F);
    send_byte(8'h00);
    send_head(8'h00);
    rx = 1'b1;
    cyc(CPB / 2 - 4);
    chk("done_early", {a_done, a_crst}, 2'b00);
    cyc(10);
    chk("done_rise", {a_done, a_crst}, 2'b11);
    cyc(CPB / 2);
    all = bs;
    all.push_back(8'hFF);
    all.push_back(8'h0F);
    all.push_back(8'h00);
    all.push_back(8'h00);
    cmp("basic", got_a, model(all, 4096));
    chk("basic_w0", 64'(got_a[0]), {12'd0, 32'h00200113});
    chk("basic_cnt", 64'(a_cnt), 64'd2);
    chk("basic_req1", 64'(req_cyc_a), 64'd2);
    chk("basic_fe", 64'(a_fe), 64'd0);
    cmp("basic_cap", got_b, model(all, 2));
    chk("basic_cap_done", 64'(b_done), 64'd1);

    // false start glitch
    do_reset();
    rx = 1'b0;
    cyc(20);
    rx = 1'b1;
    cyc(3 * CPB);
    chk("glitch_req", 64'(req_cyc_a), 64'd0);
    w = rnd_word();
    send_word(w);
    cyc(10);
    bs = '{w[7:0], w[15:8], w[23:16], w[31:24]};
    cmp("glitch", got_a, model(bs, 4096));
    chk("glitch_fe", 64'(a_fe), 64'd0);

    // framing error
    do_reset();
    send_byte(8'h55, 1'b0);
    chk("fe_set", 64'(a_fe), 64'd1);
    send_word(32'h00200113);
    cyc(10);
    bs = '{8'h13, 8'h01, 8'h20, 8'h00};
    cmp("fe", got_a, model(bs, 4096));
    chk("fe_sticky", 64'(a_fe), 64'd1);

    // grant stall and overrun
    do_reset();
    gnt = 1'b0;
    send_word(32'h11111111);
    cyc(5);
    chk("stall_a", {a_req, a_ov, a_addr, a_wdata},
        {2'b10, 12'd0, 32'h11111111});
    send_word(32'h22222222);
    cyc(5);
    chk("stall_b", {a_req, a_ov, a_addr, a_wdata},
        {2'b11, 12'd0, 32'h11111111});
    chk("stall_cnt", 64'(a_cnt), 64'd0);
    gnt = 1'b1;
    cyc(5);
    bs = '{8'h11, 8'h11, 8'h11, 8'h11};
    cmp("stall", got_a, model(bs, 4096));
    chk("stall_end", {a_req, a_cnt}, {1'b0, 13'd1});

    // reset in the middle of a byte
    do_reset();
    send_byte(8'hA5);
    rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = w[i];
      cyc(CPB);
    end
    rx = 1'b0;
    cyc(CPB / 2);
    do_reset();
    cyc(2 * CPB);
    send_word(32'h00200113);
    cyc(10);
    bs = '{8'h13, 8'h01, 8'h20, 8'h00};
    cmp("midrst", got_a, model(bs, 4096));

    // random image, with capacity on the second instance
    do_reset();
    nw = $urandom_range(4, 3);
    bs.delete();
    for (int j = 0; j < nw; j++) begin
      w = rnd_word();
      for (int i = 0; i < 4; i++) bs.push_back(w[8*i +: 8]);
    end
    send_list(bs, 20);
    chk("cap_done", 64'(b_done), 64'd1);
    chk("cap_cnt", 64'(b_cnt), 64'd2);
    send_word(ENDW);
    cyc(CPB);
    all = bs;
    for (int i = 0; i < 4; i++) all.push_back(ENDW[8*i +: 8]);
    cmp("rand", got_a, model(all, 4096));
    cmp("rand_cap", got_b, model(all, 2));
    chk("rand_done", {a_done, a_crst}, 2'b11);
    chk("rand_cnt", 64'(a_cnt), 64'(nw));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
